// File: rtl/reg_access_seq_pkg.sv
// Shared register-file constants: operation encodings and address width
// used by the register access sequencer and its environment.
package reg_access_seq_pkg;

  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned REG_COUNT = 1 << ADDR_W;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_MOVE  = 2'b11
  } op_t;

endpackage

// File: rtl/reg_access_seq.sv
// Register access sequencer: accepts NOP/READ/WRITE/MOVE commands and drives
// a registered-read register file, returning READ data over a valid/ready port.
module reg_access_seq
  import reg_access_seq_pkg::*;
#(
  parameter int unsigned Width = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [Width-1:0]  cmd_data,
  output logic              rf_read_enable,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [Width-1:0]  rf_read_data,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [Width-1:0]  rf_write_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [Width-1:0]  rsp_data,
  output logic [7:0]        cmd_count
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    CAP,
    RSP,
    MV_WR
  } state_t;

  state_t            state;
  state_t            state_next;
  op_t               op_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [Width-1:0]  data_q;
  logic              accept;
  logic              count_inc;

  assign accept = (state == IDLE) && cmd_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_NOP;
      src_q     <= '0;
      dst_q     <= '0;
      data_q    <= '0;
      rsp_data  <= '0;
      cmd_count <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q   <= op_t'(cmd_op);
        src_q  <= cmd_src;
        dst_q  <= cmd_dst;
        data_q <= cmd_data;
      end
      // Read data is only valid in CAP; MOVE reuses this register as its write source.
      if (state == CAP) begin
        rsp_data <= rf_read_data;
      end
      if (count_inc) begin
        cmd_count <= cmd_count + 8'd1;
      end
    end
  end

  always_comb begin
    state_next      = state;
    cmd_ready       = 1'b0;
    rf_read_enable  = 1'b0;
    rf_read_addr    = '0;
    rf_write_enable = 1'b0;
    rf_write_addr   = '0;
    rf_write_data   = '0;
    rsp_valid       = 1'b0;
    count_inc       = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          unique case (op_t'(cmd_op))
            OP_WRITE:         state_next = WR;
            OP_READ, OP_MOVE: state_next = RD;
            default:          state_next = IDLE;
          endcase
        end
      end
      WR: begin
        rf_write_enable = 1'b1;
        rf_write_addr   = dst_q;
        rf_write_data   = data_q;
        count_inc       = 1'b1;
        state_next      = IDLE;
      end
      RD: begin
        rf_read_enable = 1'b1;
        rf_read_addr   = src_q;
        state_next     = CAP;
      end
      CAP: begin
        state_next = (op_q == OP_MOVE) ? MV_WR : RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          count_inc  = 1'b1;
          state_next = IDLE;
        end
      end
      MV_WR: begin
        rf_write_enable = 1'b1;
        rf_write_addr   = dst_q;
        rf_write_data   = rsp_data;
        count_inc       = 1'b1;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_access_seq.sv
// Bench for reg_access_seq: 8x16 register-file model on the rf port, a
// cycle-offset transaction model, directed scenarios and random traffic.
module tb_reg_access_seq;
  import reg_access_seq_pkg::*;

  localparam int unsigned W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'b00;
  logic [ADDR_W-1:0] cmd_src = '0;
  logic [ADDR_W-1:0] cmd_dst = '0;
  logic [W-1:0]      cmd_data = '0;
  logic              rf_read_enable;
  logic [ADDR_W-1:0] rf_read_addr;
  logic [W-1:0]      rf_read_data;
  logic              rf_write_enable;
  logic [ADDR_W-1:0] rf_write_addr;
  logic [W-1:0]      rf_write_data;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [W-1:0]      rsp_data;
  logic [7:0]        cmd_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  reg_access_seq #(.Width(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_data(cmd_data),
    .rf_read_enable(rf_read_enable), .rf_read_addr(rf_read_addr),
    .rf_read_data(rf_read_data),
    .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  // Register file: registered read, junk on the data bus when no read is pending.
  logic [W-1:0] rf_mem [REG_COUNT];
  logic [W-1:0] rd_reg = '0;
  logic [W-1:0] junk = '0;
  logic         rd_hold = 1'b0;

  always @(posedge clk) begin
    if (rf_write_enable) rf_mem[rf_write_addr] <= rf_write_data;
    rd_hold <= rf_read_enable;
    if (rf_read_enable) rd_reg <= rf_mem[rf_read_addr];
  end
  always @(negedge clk) junk <= W'($urandom);
  assign rf_read_data = rd_hold ? rd_reg : junk;

  // Reference: k counts cycles since the accepting edge of the active command.
  logic [W-1:0]      ref_mem [REG_COUNT];
  bit                m_busy = 1'b0;
  op_t               m_op = OP_NOP;
  logic [ADDR_W-1:0] m_src = '0;
  logic [ADDR_W-1:0] m_dst = '0;
  logic [W-1:0]      m_data = '0;
  logic [W-1:0]      m_rd = '0;
  int unsigned       m_k = 0;
  logic [7:0]        m_count = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  = 1'b0;
      m_k     = 0;
      m_count = '0;
    end else if (!m_busy) begin
      if (cmd_valid && op_t'(cmd_op) != OP_NOP) begin
        m_busy = 1'b1;
        m_op   = op_t'(cmd_op);
        m_src  = cmd_src;
        m_dst  = cmd_dst;
        m_data = cmd_data;
        m_k    = 1;
      end
    end else if (m_k == 1) begin
      if (m_op == OP_WRITE) begin
        ref_mem[m_dst] = m_data;
        m_count = m_count + 8'd1;
        m_busy  = 1'b0;
      end else begin
        m_rd = ref_mem[m_src];
        m_k  = 2;
      end
    end else if (m_k == 2) begin
      m_k = 3;
    end else if (m_op == OP_MOVE) begin
      ref_mem[m_dst] = m_rd;
      m_count = m_count + 8'd1;
      m_busy  = 1'b0;
    end else if (rsp_ready) begin
      m_count = m_count + 8'd1;
      m_busy  = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    bit exp_re, exp_we, exp_rv;
    exp_re = m_busy && m_k == 1 && m_op != OP_WRITE;
    exp_we = m_busy && ((m_op == OP_WRITE && m_k == 1) || (m_op == OP_MOVE && m_k == 3));
    exp_rv = m_busy && m_op == OP_READ && m_k == 3;
    check("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
    check("rf_read_enable", 32'(rf_read_enable), 32'(exp_re));
    check("rf_write_enable", 32'(rf_write_enable), 32'(exp_we));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    check("cmd_count", 32'(cmd_count), 32'(m_count));
    if (exp_re) check("rf_read_addr", 32'(rf_read_addr), 32'(m_src));
    if (exp_we) begin
      check("rf_write_addr", 32'(rf_write_addr), 32'(m_dst));
      check("rf_write_data", 32'(rf_write_data), 32'((m_op == OP_WRITE) ? m_data : m_rd));
    end
    if (exp_rv) check("rsp_data", 32'(rsp_data), 32'(m_rd));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input op_t op, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                      input logic [W-1:0] dat);
    int unsigned n = 0;
    while (m_busy && n < 50) begin
      tick();
      n++;
    end
    check("send_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_src   = s;
    cmd_dst   = d;
    cmd_data  = dat;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int unsigned cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rsp_valid && cyc < 20);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_count", 32'(cmd_count), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rf_re", 32'(rf_read_enable), 32'd0);
    check("rst_rf_ra", 32'(rf_read_addr), 32'd0);
    check("rst_rf_we", 32'(rf_write_enable), 32'd0);
    check("rst_rf_wa", 32'(rf_write_addr), 32'd0);
    check("rst_rf_wd", 32'(rf_write_data), 32'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int unsigned cyc;
    for (int i = 0; i < int'(REG_COUNT); i++) begin
      logic [W-1:0] v;
      v = W'($urandom);
      rf_mem[i] <= v;
      ref_mem[i] = v;
    end
    #1;
    do_reset();

    // WRITE then READ with latency and count pinned to literals.
    send(OP_WRITE, 3'd0, 3'd3, 16'hA5A5);
    send(OP_READ, 3'd3, 3'd0, 16'h0000);
    wait_rsp(cyc);
    check("read_latency", cyc, 32'd3);
    check("read_a5a5", 32'(rsp_data), 32'h0000_A5A5);
    tick();
    check("count_after_two", 32'(cmd_count), 32'd2);

    // MOVE r1 -> r6, no response during the move.
    send(OP_WRITE, 3'd0, 3'd1, 16'h1234);
    send(OP_MOVE, 3'd1, 3'd6, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("move_no_rsp", 32'(rsp_valid), 32'd0);
    end
    check("move_mem6", 32'(rf_mem[6]), 32'h0000_1234);
    send(OP_READ, 3'd6, 3'd0, 16'h0000);
    wait_rsp(cyc);
    check("read_after_move", 32'(rsp_data), 32'h0000_1234);
    tick();

    // Response back-pressure with command pulses that must be ignored.
    rsp_ready = 1'b0;
    send(OP_READ, 3'd6, 3'd0, 16'h0000);
    wait_rsp(cyc);
    cmd_op   = OP_WRITE;
    cmd_dst  = 3'd6;
    cmd_data = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_data", 32'(rsp_data), 32'h0000_1234);
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      tick();
      cmd_valid = (i < 4) ? ~cmd_valid : 1'b0;
      if (i < 4) @(negedge clk);
    end
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    check("hold_mem6_kept", 32'(rf_mem[6]), 32'h0000_1234);

    // Reset while a MOVE into r2 is in its read cycle.
    send(OP_WRITE, 3'd0, 3'd2, 16'h0F0F);
    send(OP_WRITE, 3'd0, 3'd5, 16'hBEEF);
    send(OP_MOVE, 3'd5, 3'd2, 16'h0000);
    check("abort_in_rd", 32'(rf_read_enable), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_we", 32'(rf_write_enable), 32'd0);
    check("abort_re", 32'(rf_read_enable), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_rsp_data", 32'(rsp_data), 32'd0);
    check("abort_count", 32'(cmd_count), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_mem2", 32'(rf_mem[2]), 32'h0000_0F0F);
    tick();
    send(OP_READ, 3'd2, 3'd0, 16'h0000);
    wait_rsp(cyc);
    check("abort_read2", 32'(rsp_data), 32'h0000_0F0F);
    tick();

    // 256 WRITEs and 4 NOPs wrap the command counter back to zero.
    do_reset();
    for (int i = 0; i < 260; i++) begin
      if (i % 65 == 64) begin
        send(OP_NOP, 3'($urandom), 3'($urandom), W'($urandom));
        @(negedge clk);
        check("nop_no_we", 32'(rf_write_enable), 32'd0);
        check("nop_no_re", 32'(rf_read_enable), 32'd0);
        tick();
      end else begin
        send(OP_WRITE, 3'($urandom), 3'($urandom), W'($urandom));
      end
    end
    tick();
    @(negedge clk);
    check("count_wrap", 32'(cmd_count), 32'd0);
    tick();

    // Random traffic with random back-pressure and rare resets.
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 2'($urandom);
      cmd_src   = 3'($urandom);
      cmd_dst   = 3'($urandom);
      cmd_data  = W'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < int'(REG_COUNT); i++) begin
      check("final_mem", 32'(rf_mem[i]), 32'(ref_mem[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_access_seq.md
REG_ACCESS_SEQ -- requirements
Module: reg_access_seq

Interface
REQ-001 Parameter: Width, default 16, data width of the register file port.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  block can accept a command.
REQ-006 cmd_op  input  2  operation: 00 NOP, 01 READ, 10 WRITE, 11 MOVE.
REQ-007 cmd_src  input  3  source register address (READ, MOVE).
REQ-008 cmd_dst  input  3  destination register address (WRITE, MOVE).
REQ-009 cmd_data  input  Width  write data (WRITE only).
REQ-010 rf_read_enable  output  1  register-file read strobe.
REQ-011 rf_read_addr  output  3  register-file read address.
REQ-012 rf_read_data  input  Width  register-file read data; registered by the file on the rising edge sampling rf_read_enable; high-Z otherwise.
REQ-013 rf_write_enable  output  1  register-file write strobe.
REQ-014 rf_write_addr  output  3  register-file write address.
REQ-015 rf_write_data  output  Width  register-file write data.
REQ-016 rsp_valid  output  1  read response available.
REQ-017 rsp_ready  input  1  consumer accepts response.
REQ-018 rsp_data  output  Width  read response data.
REQ-019 cmd_count  output  8  number of completed non-NOP commands, wraps 255->0.

Function
REQ-020 FSM states: IDLE, WR, RD, CAP, RSP, MV_WR; cmd_ready SHALL be 1 only in IDLE.
REQ-021 Handshake: command accepted on a rising edge with cmd_valid=1 in IDLE; op, src, dst, data latched into internal registers at that edge.
REQ-022 NOP: accepted, stays IDLE, no strobes, cmd_count unchanged.
REQ-023 WRITE: IDLE->WR; WR drives rf_write_enable=1, rf_write_addr=dst, rf_write_data=data for exactly one cycle; WR->IDLE.
REQ-024 READ: IDLE->RD (rf_read_enable=1, rf_read_addr=src, one cycle)->CAP (rf_read_data captured into rsp_data at end of CAP)->RSP.
REQ-025 RSP: rsp_valid=1 and rsp_data stable until a rising edge with rsp_ready=1; then ->IDLE.
REQ-026 READ latency: rsp_valid asserts in the 3rd cycle after the accepting edge; rsp_ready held high gives 4-cycle command-to-command throughput.
REQ-027 MOVE: IDLE->RD->CAP->MV_WR; MV_WR writes captured data to dst for one cycle, ->IDLE; rsp_valid never asserts for MOVE.
REQ-028 MOVE with src==dst SHALL still perform read and write (value unchanged).
REQ-029 rf_read_enable and rf_write_enable SHALL never be 1 in the same cycle; strobes are 0 in all other states.
REQ-030 rf_read_data SHALL be sampled only in CAP; high-Z in other cycles never propagates to rsp_data.
REQ-031 cmd_count increments by 1 on leaving WR, MV_WR, or RSP (on rsp handshake).
REQ-032 cmd_valid while busy is ignored (not queued); rsp_ready outside RSP is ignored.

Reset
REQ-033 rst=1 SHALL asynchronously force IDLE, cmd_count=0, rsp_data=0, rsp_valid=0, all rf_* outputs 0, latched command cleared.
REQ-034 Reset mid-operation SHALL abort the command: no write strobe after rst asserts, pending response discarded.
REQ-035 First command may be accepted on the first rising edge after rst deasserts.

Structure
REQ-036 Op encodings (NOP/READ/WRITE/MOVE) and the 3-bit address width SHALL be constants in the shared register-file package.
REQ-037 FSM state encoding SHALL be local to the module; no sub-module; single flat block.

Verification
REQ-038 Bench connects the block to the team's 8x16 register-file model.
REQ-039 WRITE dst=3 data=16'hA5A5, then READ src=3 -> rsp_valid 3 cycles after accept, rsp_data=16'hA5A5, cmd_count=2.
REQ-040 WRITE r1=16'h1234, MOVE src=1 dst=6, READ src=6 -> rsp_data=16'h1234, no rsp_valid during MOVE.
REQ-041 READ with rsp_ready low 5 cycles -> rsp_valid and rsp_data held 5 cycles, cmd_ready=0 throughout, cmd_valid pulses ignored.
REQ-042 rst asserted during RD of a MOVE to r2 (r2=16'h0F0F) -> r2 still 16'h0F0F, all outputs 0, cmd_ready=1 after release.
REQ-043 256 WRITEs plus 4 NOPs -> cmd_count=0 (wrap), NOPs produce no strobes.
